// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: OAM DMA state encoding and register map constants.
package ppu_pkg;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE
  } dma_state_t;

  localparam logic [2:0]  OAMDATA_REG  = 3'd4;
  localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
  localparam int          DMA_IDX_W    = 8;

endpackage

// File: rtl/oam_dma_if.sv
// CPU bus, DMA memory read port and PPU register write port of the sprite DMA engine.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_we;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        ppu_cs_n;
  logic        ppu_we;
  logic [2:0]  ppu_reg_addr;
  logic [7:0]  ppu_data;

  modport master (
    input  cpu_addr, cpu_data_in, cpu_we, mem_data,
    output cpu_rdy, dma_active, mem_addr, mem_rd,
    output ppu_cs_n, ppu_we, ppu_reg_addr, ppu_data
  );

  modport slave (
    output cpu_addr, cpu_data_in, cpu_we, mem_data,
    input  cpu_rdy, dma_active, mem_addr, mem_rd,
    input  ppu_cs_n, ppu_we, ppu_reg_addr, ppu_data
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: halts the CPU and copies one 256-byte page into OAM via OAMDATA writes.
module oam_dma
  import ppu_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = OAM_DMA_ADDR,
    parameter int          NUM_BYTES    = 256,
    parameter bit          ALIGN_ODD    = 1'b1
) (
    input logic clk,
    input logic reset,
    oam_dma_if.master bus
);

    localparam logic [DMA_IDX_W-1:0] LAST_IDX = DMA_IDX_W'(NUM_BYTES - 1);

    dma_state_t           state;
    dma_state_t           next;
    logic [DMA_IDX_W-1:0] idx;
    logic [7:0]           page;
    logic                 cycle_odd;
    logic                 trigger;
    logic                 last;

    assign trigger = bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR);
    assign last    = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= DMA_IDLE;
            idx       <= '0;
            page      <= '0;
            cycle_odd <= 1'b0;
        end else begin
            state     <= next;
            cycle_odd <= ~cycle_odd;
            if (state == DMA_IDLE && trigger) begin
                page <= bus.cpu_data_in;
                idx  <= '0;
            end else if (state == DMA_WRITE && !last) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            DMA_IDLE:  if (trigger) next = DMA_HALT;
            DMA_HALT:  next = (ALIGN_ODD && cycle_odd) ? DMA_ALIGN : DMA_READ;
            DMA_ALIGN: next = DMA_READ;
            DMA_READ:  next = DMA_WRITE;
            DMA_WRITE: next = last ? DMA_IDLE : DMA_READ;
            default:   next = DMA_IDLE;
        endcase
    end

    // Outputs depend on registered state only; ppu_data forwards the RAM byte.
    always_comb begin
        bus.cpu_rdy      = 1'b1;
        bus.dma_active   = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_rd       = 1'b0;
        bus.ppu_cs_n     = 1'b1;
        bus.ppu_we       = 1'b0;
        bus.ppu_reg_addr = OAMDATA_REG;
        bus.ppu_data     = '0;
        unique case (state)
            DMA_IDLE: begin
            end
            DMA_HALT, DMA_ALIGN: begin
                bus.cpu_rdy    = 1'b0;
                bus.dma_active = 1'b1;
            end
            DMA_READ: begin
                bus.cpu_rdy    = 1'b0;
                bus.dma_active = 1'b1;
                bus.mem_addr   = {page, idx};
                bus.mem_rd     = 1'b1;
            end
            DMA_WRITE: begin
                bus.cpu_rdy    = 1'b0;
                bus.dma_active = 1'b1;
                bus.ppu_cs_n   = 1'b0;
                bus.ppu_we     = 1'b1;
                bus.ppu_data   = bus.mem_data;
            end
            default: begin
            end
        endcase
    end

endmodule
